// File: rtl/sdram_ex_pkg.sv
// Shared types and constants for the SDRAM example-design read checker.
// The lane LFSR step lives here so every user agrees on the polynomial.
package sdram_ex_pkg;

    localparam int LFSR_W = 8;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] ERR_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    // Galois step, taps 0x1D: q7 feeds back into bits 0, 2, 3 and 4.
    function automatic logic [LFSR_W-1:0] lfsr8_step(input logic [LFSR_W-1:0] q);
        lfsr8_step = {q[6], q[5], q[4], q[3] ^ q[7], q[2] ^ q[7], q[1] ^ q[7], q[0], q[7]};
    endfunction

endpackage

// File: rtl/sdram_ex_chk_lfsr8.sv
// One byte lane of the expected-pattern generator.
// load has priority over step; reset returns the lane to its seed.
module sdram_ex_chk_lfsr8
    import sdram_ex_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = lfsr8_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sdram_ex_read_checker.sv
// Compares SDRAM read beats against a locally regenerated per-lane LFSR pattern
// and reports pass/fail, a saturating error count and the first failing beat.
module sdram_ex_read_checker
    import sdram_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BEATS  = 256,
    parameter int SEED       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      first_err_beat,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  spurious
);

    localparam int L = DATA_WIDTH / LFSR_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    chk_state_t            state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;
    logic [CNT_W-1:0]      first_err_beat_q, first_err_beat_d;
    logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
    logic                  spurious_q, spurious_d;

    logic                  lfsr_load;
    logic                  lfsr_step;
    logic [DATA_WIDTH-1:0] exp_word;

    // Lane i occupies bits [8i+7:8i] of the expected word.
    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_lane
            localparam logic [LFSR_W-1:0] LANE_SEED = LFSR_W'((SEED + gi) % 256);

            sdram_ex_chk_lfsr8 #(
                .SEED (LANE_SEED)
            ) u_lfsr (
                .clk   (clk),
                .reset (reset),
                .load  (lfsr_load),
                .step  (lfsr_step),
                .state (exp_word[gi*LFSR_W +: LFSR_W])
            );
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        beat_cnt_d       = beat_cnt_q;
        err_count_d      = err_count_q;
        first_err_beat_d = first_err_beat_q;
        first_err_data_d = first_err_data_q;
        spurious_d       = spurious_q;
        lfsr_load        = 1'b0;
        lfsr_step        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // An arm beats a coincident read beat: that beat is dropped silently.
                if (start) begin
                    state_d          = ST_RUN;
                    lfsr_load        = 1'b1;
                    beat_cnt_d       = '0;
                    err_count_d      = '0;
                    first_err_beat_d = '0;
                    first_err_data_d = '0;
                    spurious_d       = 1'b0;
                end else if (rd_valid) begin
                    spurious_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (rd_valid) begin
                    lfsr_step  = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (rd_data != exp_word) begin
                        if (err_count_q != ERR_SAT) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (err_count_q == '0) begin
                            first_err_beat_d = beat_cnt_q;
                            first_err_data_d = rd_data;
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            beat_cnt_q       <= '0;
            err_count_q      <= '0;
            first_err_beat_q <= '0;
            first_err_data_q <= '0;
            spurious_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            err_count_q      <= err_count_d;
            first_err_beat_q <= first_err_beat_d;
            first_err_data_q <= first_err_data_d;
            spurious_q       <= spurious_d;
        end
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_count_q == '0);
    assign err_count      = err_count_q;
    assign first_err_beat = first_err_beat_q;
    assign first_err_data = first_err_data_q;
    assign spurious       = spurious_q;

endmodule

// File: tb/tb_sdram_ex_read_checker.sv
// Self-checking bench for sdram_ex_read_checker: a 4-beat instance for the functional
// runs and a 65535-beat instance for error-count saturation.
module tb_sdram_ex_read_checker;

    localparam int NB     = 4;
    localparam int SAT_NB = 65535;

    logic        clk = 1'b0;
    logic        reset;

    logic        start, rd_valid;
    logic [31:0] rd_data;
    logic        busy, done, pass, spurious;
    logic [15:0] err_count, first_err_beat;
    logic [31:0] first_err_data;

    logic        s_start, s_rd_valid;
    logic [31:0] s_rd_data;
    logic        s_busy, s_done, s_pass, s_spurious;
    logic [15:0] s_err_count, s_first_err_beat;
    logic [31:0] s_first_err_data;

    int          check_cnt = 0;
    int          fail_cnt  = 0;
    int          m_lane[4];
    logic [31:0] xmask[4];

    always #5 clk = ~clk;

    sdram_ex_read_checker #(.DATA_WIDTH(32), .NUM_BEATS(NB), .SEED(32)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_beat (first_err_beat),
        .first_err_data (first_err_data),
        .spurious       (spurious)
    );

    sdram_ex_read_checker #(.DATA_WIDTH(32), .NUM_BEATS(SAT_NB), .SEED(32)) u_sat (
        .clk            (clk),
        .reset          (reset),
        .start          (s_start),
        .rd_valid       (s_rd_valid),
        .rd_data        (s_rd_data),
        .busy           (s_busy),
        .done           (s_done),
        .pass           (s_pass),
        .err_count      (s_err_count),
        .first_err_beat (s_first_err_beat),
        .first_err_data (s_first_err_data),
        .spurious       (s_spurious)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pattern: each lane doubles mod 256 and folds 0x1D back in when bit 7 falls off.
    function automatic int lfsr_next(input int v);
        return ((v * 2) % 256) ^ ((v >= 128) ? 29 : 0);
    endfunction

    task automatic model_seed();
        for (int i = 0; i < 4; i++) m_lane[i] = (32 + i) % 256;
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) m_lane[i] = lfsr_next(m_lane[i]);
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w = w | (32'(m_lane[i] & 255) << (8 * i));
        return w;
    endfunction

    task automatic do_run(input string name, input int maxgap, input bit start_mid, input bit arm_with_valid);
        int          exp_err   = 0;
        int          exp_fbeat = 0;
        logic [31:0] exp_fdata = '0;
        logic [31:0] w;
        int          gaps;

        start = 1'b1;
        if (arm_with_valid) begin
            rd_valid = 1'b1;
            rd_data  = $urandom;
        end
        tick();
        start    = 1'b0;
        rd_valid = 1'b0;
        check_eq({name, "_busy_after_start"}, 64'(busy), 64'(1));
        check_eq({name, "_spurious_cleared"}, 64'(spurious), 64'(0));
        check_eq({name, "_done_cleared"}, 64'(done), 64'(0));

        model_seed();
        for (int b = 0; b < NB; b++) begin
            gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gaps) tick();
            if (start_mid && b == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check_eq({name, "_start_ignored_busy"}, 64'(busy), 64'(1));
            end
            w = model_word() ^ xmask[b];
            if (xmask[b] != 32'h0) begin
                if (exp_err == 0) begin
                    exp_fbeat = b;
                    exp_fdata = w;
                end
                exp_err++;
            end
            rd_valid = 1'b1;
            rd_data  = w;
            tick();
            rd_valid = 1'b0;
            model_step();
            if (b < NB - 1) check_eq({name, "_not_done_early"}, 64'(done), 64'(0));
        end

        check_eq({name, "_done"}, 64'(done), 64'(1));
        check_eq({name, "_busy_fall"}, 64'(busy), 64'(0));
        check_eq({name, "_pass"}, 64'(pass), 64'(exp_err == 0));
        check_eq({name, "_err_count"}, 64'(err_count), 64'(exp_err));
        check_eq({name, "_first_err_beat"}, 64'(first_err_beat), 64'(exp_fbeat));
        check_eq({name, "_first_err_data"}, 64'(first_err_data), 64'(exp_fdata));
        $display("run %s: err_count=%0d first_err_beat=%0d first_err_data=0x%08h pass=%0d",
                 name, err_count, first_err_beat, first_err_data, pass);
    endtask

    initial begin
        logic [31:0] sat_first;

        reset      = 1'b1;
        start      = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        s_start    = 1'b0;
        s_rd_valid = 1'b0;
        s_rd_data  = '0;
        for (int i = 0; i < 4; i++) xmask[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_pass", 64'(pass), 64'(0));
        check_eq("rst_spurious", 64'(spurious), 64'(0));
        check_eq("rst_err_count", 64'(err_count), 64'(0));
        check_eq("rst_first_err_beat", 64'(first_err_beat), 64'(0));
        check_eq("rst_first_err_data", 64'(first_err_data), 64'(0));
        reset = 1'b0;
        tick();

        // Read beat while idle
        rd_valid = 1'b1;
        rd_data  = $urandom;
        tick();
        rd_valid = 1'b0;
        check_eq("idle_spurious", 64'(spurious), 64'(1));
        check_eq("idle_stays_idle", 64'(busy), 64'(0));
        $display("txn spurious beat in IDLE: spurious=%0d", spurious);

        do_run("clean", 0, 1'b0, 1'b0);

        // Read beat after done: flagged, results untouched
        rd_valid = 1'b1;
        rd_data  = $urandom;
        tick();
        rd_valid = 1'b0;
        check_eq("done_spurious", 64'(spurious), 64'(1));
        check_eq("done_held", 64'(done), 64'(1));
        check_eq("done_err_unchanged", 64'(err_count), 64'(0));
        $display("txn spurious beat in DONE: spurious=%0d", spurious);

        xmask[1] = 32'h0000_0100;
        xmask[3] = 32'h0000_0001;
        do_run("corrupt", 0, 1'b0, 1'b1);
        check_eq("corrupt_first_err_data_const", 64'(first_err_data), 64'(32'h4644_4340));
        xmask[1] = '0;
        xmask[3] = '0;

        do_run("gapped", 4, 1'b0, 1'b0);
        do_run("restart_mid", 3, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                xmask[i] = ($urandom_range(1, 0) == 1) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
            end
            do_run("random", 3, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) xmask[i] = '0;

        // Reset after beat 2 of a corrupted run
        start = 1'b1;
        tick();
        start = 1'b0;
        model_seed();
        for (int b = 0; b < 3; b++) begin
            rd_valid = 1'b1;
            rd_data  = model_word() ^ ((b == 1) ? 32'h0000_0100 : 32'h0);
            tick();
            rd_valid = 1'b0;
            model_step();
        end
        check_eq("prereset_err_count", 64'(err_count), 64'(1));
        check_eq("prereset_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_done", 64'(done), 64'(0));
        check_eq("midrst_pass", 64'(pass), 64'(0));
        check_eq("midrst_err_count", 64'(err_count), 64'(0));
        check_eq("midrst_first_err_beat", 64'(first_err_beat), 64'(0));
        check_eq("midrst_first_err_data", 64'(first_err_data), 64'(0));
        $display("txn reset mid-run: busy=%0d err_count=%0d", busy, err_count);
        tick();
        reset = 1'b0;
        tick();
        do_run("after_reset", 2, 1'b0, 1'b0);

        // Saturation: every beat of a maximum-length run is wrong
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        model_seed();
        sat_first = ~model_word();
        for (int k = 0; k < SAT_NB; k++) begin
            s_rd_valid = 1'b1;
            s_rd_data  = ~model_word();
            tick();
            model_step();
            if (k == SAT_NB - 2) begin
                check_eq("sat_err_penultimate", 64'(s_err_count), 64'(SAT_NB - 1));
                check_eq("sat_not_done_early", 64'(s_done), 64'(0));
            end
        end
        s_rd_valid = 1'b0;
        check_eq("sat_done", 64'(s_done), 64'(1));
        check_eq("sat_pass", 64'(s_pass), 64'(0));
        check_eq("sat_err_count", 64'(s_err_count), 64'(16'hFFFF));
        check_eq("sat_first_err_beat", 64'(s_first_err_beat), 64'(0));
        check_eq("sat_first_err_data", 64'(s_first_err_data), 64'(sat_first));
        $display("run saturation: err_count=0x%04h first_err_beat=%0d", s_err_count, s_first_err_beat);

        // One more wrong beat after done must not disturb the saturated count
        s_rd_valid = 1'b1;
        s_rd_data  = '0;
        tick();
        s_rd_valid = 1'b0;
        check_eq("sat_hold_after_done", 64'(s_err_count), 64'(16'hFFFF));
        check_eq("sat_spurious", 64'(s_spurious), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
